ws2812b_tx_peripheral: RTL and testbench
========================================

WS2812B_TX_PERIPHERAL -- requirements
Module: ws2812b_tx_peripheral

Interface
REQ-001 SHALL have ports: clk  input  1  TinyQV project clock, nominally 64 MHz.
REQ-002 SHALL have ports: rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-003 SHALL have ports: ui_in  input  8  input PMOD, unused.
REQ-004 SHALL have ports: uo_out  output  8  serial data DOUT replicated on all 8 bits.
REQ-005 SHALL have ports: address  input  4  register address.
REQ-006 SHALL have ports: data_write  input  1  write strobe.
REQ-007 SHALL have ports: data_in  input  8  write data, valid with data_write.
REQ-008 SHALL have ports: data_out  output  8  combinational read data selected by address.
REQ-009 SHALL have the following register map (default, meaning):
- 0x0 R: 0x00, red.
- 0x1 G: 0x00, green.
- 0x2 B: 0x00, blue.
- 0x3 START: write-only, any value starts a frame.
- 0x4 STATUS: read 0xFF when busy, else 0x00.
- 0x6/0x7 LATCH_TICKS lo/hi: 3840, DOUT-low latch cycles (60 us).
- 0x8 T0H: 26, high cycles for a 0 bit.
- 0x9 T1H: 51, high cycles for a 1 bit.
- 0xA PERIOD: 80, bit period cycles.
- 0xC LED_COUNT: 1, macro-dependent (see REQ-026).
REQ-010 SHALL read 0x00 from all unlisted addresses and from 0x3; 0x0-0x2 and 0x6-0xC SHALL read back their stored values.

Function
REQ-011 SHALL implement FSM states IDLE, HIGH, LOW, LATCH.
REQ-012 SHALL, on a START write in IDLE, at the next edge:
- snapshot T0H, T1H, PERIOD, LATCH_TICKS and LED_COUNT;
- load the 24-bit shift register with {G,R,B};
- enter HIGH with DOUT=1 and busy=1.
REQ-013 SHALL transmit MSB first, G[7] first, B[0] last (24 bits per LED).
REQ-014 SHALL hold HIGH for max(TxH,1) cycles, where TxH is T1H for a 1 bit and T0H for a 0 bit, then go to LOW.
REQ-015 SHALL hold LOW for PERIOD-TxH cycles, or 1 cycle when TxH >= PERIOD; 8-bit unsigned arithmetic, no wrap.
REQ-016 SHALL, after LOW of a non-final bit, shift and return to HIGH with no gap cycle.
REQ-017 SHALL, after bit 24 of an LED with LEDs remaining, reload the shift register from the live G,R,B registers and continue at HIGH.
REQ-018 SHALL, after bit 24 of the final LED, enter LATCH with DOUT=0 for max(LATCH_TICKS,1) cycles, then IDLE with busy=0.
REQ-019 SHALL ignore START writes while busy.
REQ-020 SHALL accept timing-register writes at any time; they take effect only at the next START.
REQ-021 SHALL accept color writes at any time; they take effect at the next LED reload.
REQ-022 SHALL drive DOUT from a flop only (glitch-free); DOUT=0 in IDLE and LATCH.

Reset
REQ-023 SHALL, on rst_n low and independent of clk, asynchronously force:
- state IDLE, DOUT=0, busy=0, shift register and counters to 0;
- all registers to the defaults of REQ-009.
REQ-024 SHALL abort any frame in progress on reset mid-frame, with uo_out=0x00 immediately.

Configuration
REQ-025 SHALL use macro WS2812B_TX_MULTI_LED_EN.
REQ-026 SHALL, when WS2812B_TX_MULTI_LED_EN is defined:
- make LED_COUNT (0xC, 8-bit) writable;
- send LED_COUNT consecutive LEDs per START;
- treat 0 as 1.
REQ-027 SHALL, when WS2812B_TX_MULTI_LED_EN is undefined, send exactly one LED per START; 0xC reads 0x00 and writes to it are ignored.

Structure
REQ-028 SHALL place register address constants, default timing constants and the FSM state encoding in shared package ws2812b_tx_pkg.
REQ-029 SHALL use one sub-module ws2812b_tx_bit_timer (HIGH/LOW phase down-counter with phase-done pulse), instantiated once.

Verification
REQ-030 SHALL cover: G=0x80,R=0x00,B=0x01, START -> busy next cycle; first bit high 51 and low 29; bits 2-23 high 26 and low 54; last bit high 51; then 3840 low; STATUS 0x00 after.
REQ-031 SHALL cover: START written again mid-frame -> frame length unchanged, exactly 24 bits sent.
REQ-032 SHALL cover: T1H=90, PERIOD=80 written, then START with G=0xFF -> first bit high 90 and low 1 cycle.
REQ-033 SHALL cover: rst_n asserted at bit 10 -> uo_out=0x00 with no clk edge; STATUS=0x00; T0H reads 26.
REQ-034 SHALL cover: WS2812B_TX_MULTI_LED_EN defined, LED_COUNT=3, G changed during LED 1 -> 72 bits; LED 1 old G, LEDs 2-3 new G; a single latch.
REQ-035 SHALL cover: LATCH_TICKS=0 -> latch lasts 1 cycle; back-to-back START after busy=0 is accepted.

Source files
------------

// File: rtl/ws2812b_tx_pkg.sv
// Shared constants, FSM encoding and timing snapshot type for the WS2812B
// transmitter peripheral (register map, reset defaults, field widths).
package ws2812b_tx_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned SHIFT_W   = 24;
   localparam int unsigned BIT_CNT_W = 5;

   localparam logic [ADDR_W-1:0] ADDR_R         = 4'h0;
   localparam logic [ADDR_W-1:0] ADDR_G         = 4'h1;
   localparam logic [ADDR_W-1:0] ADDR_B         = 4'h2;
   localparam logic [ADDR_W-1:0] ADDR_START     = 4'h3;
   localparam logic [ADDR_W-1:0] ADDR_STATUS    = 4'h4;
   localparam logic [ADDR_W-1:0] ADDR_LATCH_LO  = 4'h6;
   localparam logic [ADDR_W-1:0] ADDR_LATCH_HI  = 4'h7;
   localparam logic [ADDR_W-1:0] ADDR_T0H       = 4'h8;
   localparam logic [ADDR_W-1:0] ADDR_T1H       = 4'h9;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD    = 4'hA;
   localparam logic [ADDR_W-1:0] ADDR_LED_COUNT = 4'hC;

   localparam logic [CNT_W-1:0]  LATCH_TICKS_DEF = 16'd3840;
   localparam logic [DATA_W-1:0] T0H_DEF         = 8'd26;
   localparam logic [DATA_W-1:0] T1H_DEF         = 8'd51;
   localparam logic [DATA_W-1:0] PERIOD_DEF      = 8'd80;
   localparam logic [DATA_W-1:0] LED_COUNT_DEF   = 8'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_LATCH
   } state_t;

   // Timing registers as a group, so a START can freeze them in one move
   typedef struct packed {
      logic [CNT_W-1:0]  latch_ticks;
      logic [DATA_W-1:0] t0h;
      logic [DATA_W-1:0] t1h;
      logic [DATA_W-1:0] period;
   } timing_t;

   localparam timing_t TIMING_DEF = '{
      latch_ticks: LATCH_TICKS_DEF,
      t0h:         T0H_DEF,
      t1h:         T1H_DEF,
      period:      PERIOD_DEF
   };

   // Phase lengths of zero are stretched to one cycle
   function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/ws2812b_tx_bit_timer.sv
// Phase down-counter for the HIGH, LOW and LATCH phases.
// Ports: clk, rst_n (async active-low), load / load_val (start a phase of
// load_val cycles), phase_done_c (combinational, high in the last cycle).
module ws2812b_tx_bit_timer
   import ws2812b_tx_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             phase_done_c
);

   logic [CNT_W-1:0] count;

   // Count down to 1; the cycle holding 1 is the last cycle of the phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign phase_done_c = (count == CNT_W'(1));

endmodule

// File: rtl/ws2812b_tx_peripheral.sv
// WS2812B single-wire LED transmitter with a small register file.
// Ports: clk, rst_n (async active-low), ui_in (unused), uo_out (DOUT on all
// bits), address / data_write / data_in (register write), data_out
// (combinational register read).
// Build option: WS2812B_TX_MULTI_LED_EN makes LED_COUNT writable and sends
// that many LEDs per START; otherwise one LED per START.
module ws2812b_tx_peripheral
   import ws2812b_tx_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] ui_in,
   output logic [DATA_W-1:0] uo_out,
   input  logic [ADDR_W-1:0] address,
   input  logic              data_write,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0]    red;
   logic [DATA_W-1:0]    green;
   logic [DATA_W-1:0]    blue;
   timing_t              cfg;
   timing_t              snap;
`ifdef WS2812B_TX_MULTI_LED_EN
   logic [DATA_W-1:0]    led_count;
`endif
   state_t               state;
   logic                 dout;
   logic [SHIFT_W-1:0]   shreg;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [DATA_W-1:0]    leds_left;

   logic                 busy_c;
   logic                 start_c;
   logic                 last_bit_c;
   logic                 last_led_c;
   logic                 next_bit_c;
   logic [DATA_W-1:0]    start_txh_c;
   logic [DATA_W-1:0]    txh_c;
   logic [DATA_W-1:0]    next_txh_c;
   logic [DATA_W-1:0]    low_len_c;
   logic [DATA_W-1:0]    first_leds_c;
   logic                 tmr_load_c;
   logic [CNT_W-1:0]     tmr_val_c;
   logic                 phase_done_c;
   logic                 unused_c;

   assign unused_c = ^ui_in;
   assign busy_c   = (state != ST_IDLE);
   assign start_c  = data_write && (address == ADDR_START) && !busy_c;
   assign uo_out   = {DATA_W{dout}};

`ifdef WS2812B_TX_MULTI_LED_EN
   assign first_leds_c = (led_count == '0) ? DATA_W'(1) : led_count;
`else
   assign first_leds_c = DATA_W'(1);
`endif

   // Bit timing: current bit from the frozen snapshot, first bit from live config
   assign start_txh_c = green[DATA_W-1] ? cfg.t1h : cfg.t0h;
   assign txh_c       = shreg[SHIFT_W-1] ? snap.t1h : snap.t0h;
   assign low_len_c   = (txh_c >= snap.period) ? DATA_W'(1) : DATA_W'(snap.period - txh_c);
   assign last_bit_c  = (bit_cnt == BIT_CNT_W'(SHIFT_W - 1));
   assign last_led_c  = (leds_left <= DATA_W'(1));
   assign next_bit_c  = last_bit_c ? green[DATA_W-1] : shreg[SHIFT_W-2];
   assign next_txh_c  = next_bit_c ? snap.t1h : snap.t0h;

   // Register file writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         cfg   <= TIMING_DEF;
`ifdef WS2812B_TX_MULTI_LED_EN
         led_count <= LED_COUNT_DEF;
`endif
      end else if (data_write) begin
         case (address)
            ADDR_R:         red                        <= data_in;
            ADDR_G:         green                      <= data_in;
            ADDR_B:         blue                       <= data_in;
            ADDR_LATCH_LO:  cfg.latch_ticks[7:0]       <= data_in;
            ADDR_LATCH_HI:  cfg.latch_ticks[15:8]      <= data_in;
            ADDR_T0H:       cfg.t0h                    <= data_in;
            ADDR_T1H:       cfg.t1h                    <= data_in;
            ADDR_PERIOD:    cfg.period                 <= data_in;
`ifdef WS2812B_TX_MULTI_LED_EN
            ADDR_LED_COUNT: led_count                  <= data_in;
`endif
            default: ;
         endcase
      end
   end

   // Length of the phase that starts at the coming edge
   always_comb begin
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;
      case (state)
         ST_IDLE: begin
            if (start_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = at_least_one(CNT_W'(start_txh_c));
            end
         end
         ST_HIGH: begin
            if (phase_done_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = CNT_W'(low_len_c);
            end
         end
         ST_LOW: begin
            if (phase_done_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = (last_bit_c && last_led_c) ? at_least_one(snap.latch_ticks)
                                                       : at_least_one(CNT_W'(next_txh_c));
            end
         end
         default: ;
      endcase
   end

   ws2812b_tx_bit_timer u_bit_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (tmr_load_c),
      .load_val     (tmr_val_c),
      .phase_done_c (phase_done_c)
   );

   // Frame sequencer; DOUT comes straight from a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         dout      <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         leds_left <= '0;
         snap      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_c) begin
                  snap      <= cfg;
                  shreg     <= {green, red, blue};
                  bit_cnt   <= '0;
                  leds_left <= first_leds_c;
                  state     <= ST_HIGH;
                  dout      <= 1'b1;
               end
            end
            ST_HIGH: begin
               if (phase_done_c) begin
                  state <= ST_LOW;
                  dout  <= 1'b0;
               end
            end
            ST_LOW: begin
               if (phase_done_c) begin
                  if (!last_bit_c) begin
                     shreg   <= {shreg[SHIFT_W-2:0], 1'b0};
                     bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                     state   <= ST_HIGH;
                     dout    <= 1'b1;
                  end else if (!last_led_c) begin
                     shreg     <= {green, red, blue};
                     bit_cnt   <= '0;
                     leds_left <= leds_left - DATA_W'(1);
                     state     <= ST_HIGH;
                     dout      <= 1'b1;
                  end else begin
                     state <= ST_LATCH;
                  end
               end
            end
            ST_LATCH: begin
               if (phase_done_c) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Register read mux
   always_comb begin
      data_out = '0;
      case (address)
         ADDR_R:         data_out = red;
         ADDR_G:         data_out = green;
         ADDR_B:         data_out = blue;
         ADDR_STATUS:    data_out = {DATA_W{busy_c}};
         ADDR_LATCH_LO:  data_out = cfg.latch_ticks[7:0];
         ADDR_LATCH_HI:  data_out = cfg.latch_ticks[15:8];
         ADDR_T0H:       data_out = cfg.t0h;
         ADDR_T1H:       data_out = cfg.t1h;
         ADDR_PERIOD:    data_out = cfg.period;
`ifdef WS2812B_TX_MULTI_LED_EN
         ADDR_LED_COUNT: data_out = led_count;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ws2812b_tx_peripheral.sv
// Directed bench for ws2812b_tx_peripheral: a line monitor records DOUT high
// runs, inter-bit low runs and the final low run of each frame (last-bit low
// plus latch); the main sequence checks them against hand-computed lengths.
module tb_ws2812b_tx_peripheral;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [3:0] address = 4'h4;
   logic       data_write = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;

   int checks = 0;
   int errors = 0;

   int hi_q[$];
   int lo_q[$];
   int tail_q[$];

   int   mon_run;
   logic mon_cur;
   logic mon_busy;
   logic mon_d;
   logic mon_b;

   logic [7:0] v;
   int         n;

   ws2812b_tx_peripheral dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   // Line monitor, sampled on falling clock edges
   initial begin
      mon_run = 0; mon_cur = 1'b0; mon_busy = 1'b0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            mon_run = 0; mon_cur = 1'b0; mon_busy = 1'b0;
         end else begin
            mon_d = uo_out[0];
            mon_b = (address == 4'h4) ? (data_out == 8'hFF) : mon_busy;
            if (mon_busy && !mon_b) begin
               tail_q.push_back(mon_run);
               mon_run = 0;
            end
            if (mon_d != mon_cur) begin
               if (mon_run > 0) begin
                  if (mon_cur) hi_q.push_back(mon_run);
                  else if (mon_busy) lo_q.push_back(mon_run);
               end
               mon_cur = mon_d;
               mon_run = 1;
            end else begin
               mon_run++;
            end
            mon_busy = mon_b;
         end
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      address = a; data_in = d; data_write = 1'b1;
      @(posedge clk); #1;
      data_write = 1'b0; address = 4'h4;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      address = a;
      @(negedge clk);
      d = data_out;
      @(posedge clk); #1;
      address = 4'h4;
   endtask

   task automatic wait_tail(input int cnt, input string tag);
      int k = 0;
      while (tail_q.size() < cnt && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, tail_q.size(), cnt);
   endtask

   task automatic clear_q();
      hi_q.delete(); lo_q.delete(); tail_q.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_uo_out", int'(uo_out), 0);
      rd(4'h0, v); chk("rst_r", int'(v), 0);
      rd(4'h1, v); chk("rst_g", int'(v), 0);
      rd(4'h4, v); chk("rst_status", int'(v), 0);
      rd(4'h6, v); chk("rst_latch_lo", int'(v), 8'h00);
      rd(4'h7, v); chk("rst_latch_hi", int'(v), 8'h0F);
      rd(4'h8, v); chk("rst_t0h", int'(v), 26);
      rd(4'h9, v); chk("rst_t1h", int'(v), 51);
      rd(4'hA, v); chk("rst_period", int'(v), 80);
`ifdef WS2812B_TX_MULTI_LED_EN
      rd(4'hC, v); chk("rst_led_count", int'(v), 1);
`else
      rd(4'hC, v); chk("rst_led_count", int'(v), 0);
`endif
      rd(4'h5, v); chk("rd_unmapped", int'(v), 0);
      wr(4'h2, 8'h5A);
      rd(4'h2, v); chk("rd_b_back", int'(v), 8'h5A);
      rd(4'h3, v); chk("rd_start", int'(v), 0);

      // Basic frame: G=0x80 R=0x00 B=0x01
      wr(4'h1, 8'h80); wr(4'h0, 8'h00); wr(4'h2, 8'h01);
      clear_q();
      wr(4'h3, 8'h00);
      @(negedge clk);
      chk("busy_after_start", int'(data_out), 8'hFF);
      chk("dout_after_start", int'(uo_out), 8'hFF);
      wait_tail(1, "f1_done");
      chk("f1_nhi", hi_q.size(), 24);
      chk("f1_nlo", lo_q.size(), 23);
      chk("f1_hi0", hi_q[0], 51);
      chk("f1_lo0", lo_q[0], 29);
      for (int i = 1; i < 23; i++) begin
         chk("f1_hi_zero", hi_q[i], 26);
         chk("f1_lo_zero", lo_q[i], 54);
      end
      chk("f1_hi23", hi_q[23], 51);
      chk("f1_tail", tail_q[0], 29 + 3840);
      rd(4'h4, v); chk("f1_status_idle", int'(v), 0);

      // START while busy is ignored
      clear_q();
      wr(4'h3, 8'h00);
      repeat (500) @(negedge clk);
      wr(4'h3, 8'hFF);
      wait_tail(1, "f2_done");
      chk("f2_nhi", hi_q.size(), 24);
      chk("f2_nlo", lo_q.size(), 23);
      chk("f2_tail", tail_q[0], 3869);
      repeat (50) @(negedge clk);
      chk("f2_no_restart", hi_q.size(), 24);

      // TxH >= PERIOD: LOW lasts one cycle
      wr(4'h9, 8'd90); wr(4'h1, 8'hFF); wr(4'h2, 8'h00);
      clear_q();
      wr(4'h3, 8'h00);
      wait_tail(1, "f3_done");
      chk("f3_hi0", hi_q[0], 90);
      chk("f3_lo0", lo_q[0], 1);
      chk("f3_hi7", hi_q[7], 90);
      chk("f3_lo7", lo_q[7], 1);
      chk("f3_hi8", hi_q[8], 26);
      chk("f3_lo8", lo_q[8], 54);
      chk("f3_tail", tail_q[0], 54 + 3840);

      // Asynchronous reset mid-frame at bit 10
      wr(4'h8, 8'd30);
      clear_q();
      wr(4'h3, 8'h00);
      n = 0;
      while (hi_q.size() < 9 && n < 5000) begin @(negedge clk); n++; end
      n = 0;
      while (uo_out[0] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      chk("rst_mid_at_bit10", hi_q.size(), 9);
      chk("rst_mid_dout_high", int'(uo_out), 8'hFF);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_uo_out", int'(uo_out), 0);
      chk("rst_mid_status", int'(data_out), 0);
      address = 4'h8; #1;
      chk("rst_mid_t0h", int'(data_out), 26);
      address = 4'h4;
      @(negedge clk); #2 rst_n = 1'b1;
      clear_q();

      // LATCH_TICKS=0 and back-to-back START (G=R=B=0 after reset)
      wr(4'h6, 8'h00); wr(4'h7, 8'h00);
      wr(4'h3, 8'h00);
      wait_tail(1, "f4_done");
      chk("f4_nhi", hi_q.size(), 24);
      chk("f4_tail", tail_q[0], 54 + 1);
      wr(4'h3, 8'h00);
      @(negedge clk);
      chk("f5_busy", int'(data_out), 8'hFF);
      wait_tail(2, "f5_done");
      chk("f5_nhi", hi_q.size(), 48);
      chk("f5_tail", tail_q[1], 55);

`ifdef WS2812B_TX_MULTI_LED_EN
      // Three LEDs, G changed during LED 1
      wr(4'hC, 8'd3);
      rd(4'hC, v); chk("ml_led_count", int'(v), 3);
      clear_q();
      wr(4'h3, 8'h00);
      n = 0;
      while (hi_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
      wr(4'h1, 8'hFF);
      wait_tail(1, "ml_done");
      chk("ml_nhi", hi_q.size(), 72);
      chk("ml_led1_g7", hi_q[0], 26);
      chk("ml_led1_g0", hi_q[7], 26);
      chk("ml_led2_g7", hi_q[24], 51);
      chk("ml_led2_g0", hi_q[31], 51);
      chk("ml_led2_r7", hi_q[32], 26);
      chk("ml_led3_g7", hi_q[48], 51);
      chk("ml_led3_g0", hi_q[55], 51);
      chk("ml_tail", tail_q[0], 55);
`else
      // Without the multi-LED build, LED_COUNT is inert
      wr(4'hC, 8'd3);
      rd(4'hC, v); chk("sl_led_count", int'(v), 0);
      clear_q();
      wr(4'h3, 8'h00);
      wait_tail(1, "sl_done");
      chk("sl_nhi", hi_q.size(), 24);
      chk("sl_tail", tail_q[0], 55);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
